// File: rtl/seed_block_loader.sv
// Byte-to-block loader for the SEED core: assembles NBYTES bytes into one block
// word and holds it until the core takes it. Define SEED_LOAD_MSB_FIRST_EN for big-endian assembly.
module seed_block_loader #(
   parameter int NBYTES = 16,
   parameter int CNT_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [7:0]            data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [8*NBYTES-1:0]   block_out,
   output logic                  block_valid,
   input  logic                  block_ready,
   output logic [CNT_W-1:0]      byte_cnt
);

   localparam int W = 8 * NBYTES;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends on valid, and valid never drops before the transfer.
   typedef enum logic {FILL, HOLD} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [W-1:0]     block_q, block_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     shifted;
   logic             accept;

`ifdef SEED_LOAD_MSB_FIRST_EN
   assign shifted = {shift_q[W-9:0], data_in};
`else
   assign shifted = {data_in, shift_q[W-1:8]};
`endif

   assign data_ready  = (state_q == FILL);
   assign accept      = data_valid & data_ready;
   assign block_out   = block_q;
   assign block_valid = valid_q;
   assign byte_cnt    = cnt_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      block_d = block_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = FILL;
         shift_d = '0;
         block_d = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  if (cnt_q == CNT_W'(NBYTES - 1)) begin
                     block_d = shifted;
                     valid_d = 1'b1;
                     cnt_d   = '0;
                     shift_d = '0;
                     state_d = HOLD;
                  end else begin
                     shift_d = shifted;
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // block_out is left as-is on release; it is don't-care once valid drops
               if (block_ready) begin
                  valid_d = 1'b0;
                  state_d = FILL;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FILL;
         shift_q <= '0;
         block_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         block_q <= block_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seed_block_loader.sv
// Self-checking bench for seed_block_loader: directed scenarios plus random traffic,
// all checked against a byte-queue reference model of the loader.
module tb_seed_block_loader;

   localparam int NBYTES = 16;
   localparam int CNT_W  = 5;
   localparam int W      = 8 * NBYTES;

   logic             clk;
   logic             reset_n;
   logic             clear;
   logic [7:0]       data_in;
   logic             data_valid;
   logic             data_ready;
   logic [W-1:0]     block_out;
   logic             block_valid;
   logic             block_ready;
   logic [CNT_W-1:0] byte_cnt;

   seed_block_loader #(.NBYTES(NBYTES), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .block_out   (block_out),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .byte_cnt    (byte_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference model: bytes collected so far, plus the presented block
   logic [7:0]   m_bytes[$];
   logic [W-1:0] m_block;
   bit           m_valid;

   function automatic logic [W-1:0] assemble();
      logic [W-1:0] blk;
      blk = '0;
      for (int i = 0; i < NBYTES; i++) begin
`ifdef SEED_LOAD_MSB_FIRST_EN
         blk[8*(NBYTES-1-i) +: 8] = m_bytes[i];
`else
         blk[8*i +: 8] = m_bytes[i];
`endif
      end
      return blk;
   endfunction

   task automatic model_reset();
      m_bytes.delete();
      m_block = '0;
      m_valid = 1'b0;
   endtask

   task automatic model_edge(input logic dv, input logic [7:0] d, input logic br, input logic clr);
      if (clr) begin
         model_reset();
      end else if (m_valid) begin
         if (br) m_valid = 1'b0;
      end else if (dv) begin
         m_bytes.push_back(d);
         if (m_bytes.size() == NBYTES) begin
            m_block = assemble();
            m_valid = 1'b1;
            m_bytes.delete();
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, W'(block_valid), W'(m_valid));
      check({tag, ".ready"}, W'(data_ready), W'(!m_valid));
      check({tag, ".cnt"},   W'(byte_cnt),   W'(m_bytes.size()));
      check({tag, ".block"}, block_out,      m_block);
   endtask

   // driver: apply inputs, clock once, advance model, compare just after the edge
   task automatic step(input string tag, input logic dv, input logic [7:0] d,
                       input logic br, input logic clr);
      data_valid  = dv;
      data_in     = d;
      block_ready = br;
      clear       = clr;
      @(posedge clk);
      model_edge(dv, d, br, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [W-1:0] k_blk;
      reset_n = 1'b0; clear = 1'b0; data_in = '0; data_valid = 1'b0; block_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("reset");

      // back-to-back fill
      for (int i = 0; i < 16; i++) step("b2b", 1'b1, 8'(i), 1'b0, 1'b0);
`ifdef SEED_LOAD_MSB_FIRST_EN
      k_blk = 128'h000102030405060708090A0B0C0D0E0F;
`else
      k_blk = 128'h0F0E0D0C0B0A09080706050403020100;
`endif
      check("b2b_const", block_out, k_blk);

      // backpressure while junk bytes are offered
      for (int i = 0; i < 10; i++) step("bp_hold", 1'b1, 8'hAA, 1'b0, 1'b0);
      check("bp_block_kept", block_out, k_blk);
      step("bp_release", 1'b1, 8'hAA, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step("bp_next", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
`ifdef SEED_LOAD_MSB_FIRST_EN
      k_blk = 128'h101112131415161718191A1B1C1D1E1F;
`else
      k_blk = 128'h1F1E1D1C1B1A19181716151413121110;
`endif
      check("bp_const", block_out, k_blk);
      step("bp_take", 1'b0, 8'h00, 1'b1, 1'b0);

      // gapped input
      for (int i = 0; i < 16; i++) begin
         int gaps;
         gaps = $urandom_range(0, 3);
         for (int g = 0; g < gaps; g++) step("gap_idle", 1'b0, 8'($urandom), 1'b0, 1'b0);
         step("gap_byte", 1'b1, 8'(8'hF0 + i), 1'b0, 1'b0);
      end
`ifdef SEED_LOAD_MSB_FIRST_EN
      k_blk = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
`else
      k_blk = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
`endif
      check("gap_const", block_out, k_blk);
      step("gap_take", 1'b0, 8'h00, 1'b1, 1'b0);

      // clear mid-fill drops the partial block and the byte in the clear cycle
      for (int i = 0; i < 5; i++) step("clr_pre", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      step("clr", 1'b1, 8'h99, 1'b0, 1'b1);
      check("clr_cnt_zero", W'(byte_cnt), W'(0));
      for (int i = 0; i < 16; i++) step("clr_next", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
`ifdef SEED_LOAD_MSB_FIRST_EN
      k_blk = 128'h202122232425262728292A2B2C2D2E2F;
`else
      k_blk = 128'h2F2E2D2C2B2A29282726252423222120;
`endif
      check("clr_const", block_out, k_blk);

      // async reset while holding a block: outputs clear before any clock edge
      data_valid = 1'b0; block_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      #1;
      reset_n = 1'b1;
      step("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
